// File: rtl/pixel_plot_fifo.sv
// Buffers signed, unclipped pixel writes, discards off-screen ones, and drives vga_adapter one pixel
// per cycle; also runs the full-screen clear sweep. Optional macro PLOT_DEDUP_EN drops repeated pixels.
module pixel_plot_fifo #(
    parameter int DEPTH = 16,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW:0]   in_x,
    input  logic [YW:0]   in_y,
    input  logic [CW-1:0] in_colour,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          clear_done,
    output logic [15:0]   dropped_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XW + YW + CW;
    localparam logic [XW:0]   X_LIM   = (XW+1)'(X_MAX);
    localparam logic [YW:0]   Y_LIM   = (YW+1)'(Y_MAX);
    localparam logic [XW-1:0] X_LAST  = XW'(X_MAX - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(Y_MAX - 1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_e;

    state_e        state_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          clear_pending_q;
    logic [CW-1:0] clear_colour_q;
    logic [XW-1:0] x_q, cx_q;
    logic [YW-1:0] y_q, cy_q;
    logic [CW-1:0] colour_q;
    logic          plot_q, clear_done_q;
    logic [15:0]   dropped_q;

    logic          empty_s, full_s, xfer_s, on_screen_s, dup_s;
    logic          push_s, drop_s, pop_s, enter_clear_s, sweep_last_s;
    logic [EW-1:0] entry_s, head_s;

    assign empty_s       = (wr_ptr_q == rd_ptr_q);
    assign full_s        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready      = (state_q == RUN) && !clear_pending_q && !full_s;
    assign xfer_s        = in_valid && in_ready;
    // Sign bit clear plus an unsigned bound check is the signed 0 <= v < MAX test.
    assign on_screen_s   = !in_x[XW] && ({1'b0, in_x[XW-1:0]} < X_LIM) &&
                           !in_y[YW] && ({1'b0, in_y[YW-1:0]} < Y_LIM);
    assign entry_s       = {in_x[XW-1:0], in_y[YW-1:0], in_colour};
    assign push_s        = xfer_s && on_screen_s && !dup_s;
    assign drop_s        = xfer_s && !on_screen_s;
    assign pop_s         = (state_q != CLEAR) && !empty_s;
    assign head_s        = mem_q[rd_ptr_q[AW-1:0]];
    assign enter_clear_s = (state_q == DRAIN) && empty_s;
    assign sweep_last_s  = (cx_q == X_LAST) && (cy_q == Y_LAST);

`ifdef PLOT_DEDUP_EN
    logic [EW-1:0] last_q;
    logic          last_vld_q;

    // Remembers the most recently stored pixel so octant duplicates can be skipped.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (enter_clear_s) begin
            last_vld_q <= 1'b0;
        end else if (push_s) begin
            last_q     <= entry_s;
            last_vld_q <= 1'b1;
        end
    end

    assign dup_s = last_vld_q && (last_q == entry_s);
`else
    assign dup_s = 1'b0;
`endif

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= entry_s;
        end
    end

    // Control FSM, FIFO pointers, drop counter and registered vga_adapter outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            clear_pending_q <= 1'b0;
            clear_colour_q  <= '0;
            x_q             <= '0;
            y_q             <= '0;
            colour_q        <= '0;
            plot_q          <= 1'b0;
            clear_done_q    <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            dropped_q       <= 16'd0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (drop_s && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
            clear_done_q <= 1'b0;
            plot_q       <= 1'b0;
            if (pop_s) begin
                x_q      <= head_s[EW-1 -: XW];
                y_q      <= head_s[CW +: YW];
                colour_q <= head_s[CW-1:0];
                plot_q   <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (clear_req && !clear_pending_q) begin
                        clear_pending_q <= 1'b1;
                        clear_colour_q  <= clear_colour;
                        state_q         <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enter_clear_s) begin
                        cx_q    <= '0;
                        cy_q    <= '0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    x_q      <= cx_q;
                    y_q      <= cy_q;
                    colour_q <= clear_colour_q;
                    plot_q   <= 1'b1;
                    if (sweep_last_s) begin
                        clear_done_q    <= 1'b1;
                        clear_pending_q <= 1'b0;
                        state_q         <= RUN;
                    end else if (cx_q == X_LAST) begin
                        cx_q <= '0;
                        cy_q <= cy_q + YW'(1);
                    end else begin
                        cx_q <= cx_q + XW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign colour        = colour_q;
    assign plot          = plot_q;
    assign clear_done    = clear_done_q;
    assign dropped_count = dropped_q;
    assign busy          = !empty_s || clear_pending_q || (state_q != RUN) || plot_q;

endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Scoreboard bench for pixel_plot_fifo: a queue-based model predicts every plot, a monitor compares.
module tb_pixel_plot_fifo;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, clear_done;
    logic [15:0] dropped_count;

    pixel_plot_fifo dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .clear_req(clear_req),
        .clear_colour(clear_colour), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .clear_done(clear_done), .dropped_count(dropped_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model state: expected plot stream as {x, y, colour} triples.
    int   exp_q[$];
    int   m_drop = 0;
    bit   m_pending = 0;
    bit   m_lvld = 0;
    int   m_last = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;
    int   ready_viol = 0;
    int   cyc = 0;
    int   first_plot = -1;
    int   last_plot = -1;

    function automatic int pack3(input int px, input int py, input int pc);
        return (px << 16) | (py << 8) | pc;
    endfunction

    task automatic model_pixel(input int sx, input int sy, input int c);
        int key;
        if (sx < 0 || sx >= 160 || sy < 0 || sy >= 120) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            key = pack3(sx, sy, c);
`ifdef PLOT_DEDUP_EN
            if (!(m_lvld && m_last == key)) begin
                exp_q.push_back(key);
                m_last = key;
                m_lvld = 1;
            end
`else
            exp_q.push_back(key);
`endif
        end
    endtask

    // Model: observes accepted transfers and clear requests at each rising edge.
    always @(posedge CLOCK_50) begin
        cyc++;
        if (!reset) begin
            if (in_valid && in_ready)
                model_pixel($signed(in_x), $signed(in_y), int'(in_colour));
            if (clear_req && !m_pending) begin
                m_pending = 1;
                m_lvld = 0;
                for (int j = 0; j < 120; j++)
                    for (int i = 0; i < 160; i++)
                        exp_q.push_back(pack3(i, j, int'(clear_colour)));
            end
        end
    end

    // Monitor: compares every plot against the scoreboard head.
    always @(negedge CLOCK_50) begin
        int e;
        if (!reset) begin
            if (plot) begin
                plot_cnt++;
                if (first_plot < 0) first_plot = cyc;
                last_plot = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_plot", pack3(int'(x), int'(y), int'(colour)), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("plot_pixel", pack3(int'(x), int'(y), int'(colour)), e);
                end
            end
            if (clear_done) begin
                done_cnt++;
                m_pending = 0;
            end
            if (m_pending && in_ready) ready_viol++;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Offers one pixel and waits (bounded) until it is accepted; leaves in_valid high.
    task automatic send(input int px, input int py, input int pc, output int stalls);
        bit rdy;
        int n;
        in_x = 9'(px);
        in_y = 8'(py);
        in_colour = 3'(pc);
        in_valid = 1'b1;
        stalls = 0;
        n = 0;
        do begin
            rdy = in_ready;
            if (!rdy) stalls++;
            @(posedge CLOCK_50);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < bound) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk("idle_within_bound", int'(n < bound), 1);
    endtask

    initial begin
        int st, total_st, p0, px, py, pc, n;

        // Reset state
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_xyc", pack3(int'(x), int'(y), int'(colour)), 0);
        chk("rst_drop", int'(dropped_count), 0);
        chk("rst_done", int'(clear_done), 0);
        chk("rst_ready", int'(in_ready), 1);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(posedge CLOCK_50);
        #1;

        // Single pixel with two-cycle latency
        send(10, 20, 5, st);
        idle();
        @(negedge CLOCK_50);
        chk("lat_cycle1_plot", int'(plot), 0);
        @(negedge CLOCK_50);
        chk("lat_cycle2_plot", int'(plot), 1);
        chk("lat_cycle2_pixel", pack3(int'(x), int'(y), int'(colour)), pack3(10, 20, 5));
        wait_idle(50);
        chk("single_drop", int'(dropped_count), 0);

        // Clipping boundaries
        p0 = plot_cnt;
        send(-1, 5, 1, st);
        send(160, 5, 2, st);
        send(5, 120, 3, st);
        send(159, 119, 6, st);
        idle();
        wait_idle(50);
        chk("clip_plots", plot_cnt - p0, 1);
        chk("clip_drop_const", int'(dropped_count), 3);
        chk("clip_drop_model", int'(dropped_count), m_drop);

        // Back-to-back burst of DEPTH+4
        p0 = plot_cnt;
        total_st = 0;
        first_plot = -1;
        for (int i = 0; i < 20; i++) begin
            send(i * 7, i * 5, i % 8, st);
            total_st += st;
        end
        idle();
        wait_idle(60);
        chk("burst_stalls", total_st, 0);
        chk("burst_plots", plot_cnt - p0, 20);
        chk("burst_consecutive", last_plot - first_plot + 1, 20);

        // Randomized traffic with clipping and occasional repeats
        px = 0; py = 0; pc = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                px = int'($urandom_range(0, 199)) - 20;
                py = int'($urandom_range(0, 149)) - 15;
                pc = int'($urandom_range(0, 7));
            end
            send(px, py, pc, st);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge CLOCK_50);
                #1;
            end
        end
        idle();
        wait_idle(100);
        chk("rand_drop_model", int'(dropped_count), m_drop);

        // Duplicate pixel handling
        p0 = plot_cnt;
        send(80, 70, 1, st);
        send(80, 70, 1, st);
        idle();
        wait_idle(50);
`ifdef PLOT_DEDUP_EN
        chk("dup_plots", plot_cnt - p0, 1);
`else
        chk("dup_plots", plot_cnt - p0, 2);
`endif

        // Full clear after three buffered pixels
        p0 = plot_cnt;
        send(1, 2, 3, st);
        send(4, 5, 6, st);
        send(7, 8, 1, st);
        idle();
        clear_req = 1'b1;
        clear_colour = 3'd4;
        @(posedge CLOCK_50);
        #1 clear_req = 1'b0;
        clear_colour = 3'd0;
        n = 0;
        while (m_pending && n < 20000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk("clear_finished", int'(m_pending), 0);
        wait_idle(20);
        chk("clear_plots", plot_cnt - p0, 3 + 19200);
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_ready_low", ready_viol, 0);

        // Reset during the clear sweep
        clear_req = 1'b1;
        clear_colour = 3'd2;
        @(posedge CLOCK_50);
        #1 clear_req = 1'b0;
        n = 0;
        while (exp_q.size() > 19200 - 500 && n < 2000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk("sweep_reached_500", int'(exp_q.size() <= 19200 - 500), 1);
        reset = 1'b1;
        exp_q.delete();
        m_pending = 0;
        m_lvld = 0;
        m_drop = 0;
        @(posedge CLOCK_50);
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_drop", int'(dropped_count), 0);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        p0 = plot_cnt;
        send(33, 44, 7, st);
        idle();
        wait_idle(50);
        chk("post_rst_plots", plot_cnt - p0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
